// File: rtl/grid_pkg.sv
// Shared object encoding and default grid size for the frame tracker.
package grid_pkg;
  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 12;

  typedef enum logic [2:0] {
    OBJ_NONE   = 3'b000,
    OBJ_HEAD   = 3'b001,
    OBJ_BODY   = 3'b010,
    OBJ_APPLE  = 3'b011,
    OBJ_BORDER = 3'b100
  } obj_code_t;

  // Border dominates so walls drawn over snake/apple still read as walls.
  function automatic obj_code_t encode(input logic head, input logic body,
                                       input logic apple, input logic border);
    if (border)     return OBJ_BORDER;
    else if (head)  return OBJ_HEAD;
    else if (body)  return OBJ_BODY;
    else if (apple) return OBJ_APPLE;
    else            return OBJ_NONE;
  endfunction
endpackage

// File: rtl/grid_scan_counter.sv
// Raster x/y scan over the grid, advancing one cell per enabled cycle.
module grid_scan_counter #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic x_end, y_end;

  assign x_end = (x == XW'(GRID_W - 1));
  assign y_end = (y == YW'(GRID_H - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end
endmodule

// File: rtl/grid_frame_tracker.sv
// Encodes per-cell object flags, diffs them against the previous frame and counts changes.
module grid_frame_tracker
  import grid_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H),
  parameter int CW     = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  input  logic          head,
  input  logic          body,
  input  logic          apple,
  input  logic          border,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [2:0]    obj_code,
  output logic          diff,
  output logic [XW-1:0] code_x,
  output logic [YW-1:0] code_y,
  output logic          code_valid,
  output logic          frame_done,
  output logic [CW-1:0] frame_diff_count
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW    = $clog2(CELLS);

  logic          last;
  logic [AW-1:0] idx;
  logic [2:0]    new_code;
  logic [2:0]    old_code;
  logic          changed;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_next;
  logic [2:0]    hist [CELLS];

  grid_scan_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW)) u_scan (
    .clk    (clk),
    .nrst   (nrst),
    .enable (enable),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  assign idx      = AW'(y) * AW'(GRID_W) + AW'(x);
  assign new_code = encode(head, body, apple, border);
  assign old_code = hist[idx];
  assign changed  = (new_code != old_code);
  assign run_next = run_cnt + CW'(changed);

  // Read-old/write-new in one cycle; reset clears history so frame one diffs against empty.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < CELLS; i++) hist[i] <= '0;
    end else if (enable) begin
      hist[idx] <= new_code;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      obj_code         <= '0;
      diff             <= 1'b0;
      code_x           <= '0;
      code_y           <= '0;
      code_valid       <= 1'b0;
      frame_done       <= 1'b0;
      frame_diff_count <= '0;
      run_cnt          <= '0;
    end else begin
      code_valid <= enable;
      frame_done <= enable && last;
      if (enable) begin
        obj_code <= new_code;
        diff     <= changed;
        code_x   <= x;
        code_y   <= y;
        if (last) begin
          frame_diff_count <= run_next;
          run_cnt          <= '0;
        end else begin
          run_cnt <= run_next;
        end
      end
    end
  end
endmodule
